// File: rtl/ddr3_request_arbiter_pkg.sv
// Shared types and widths for the DDR3 byte-port arbiter and its picker.
// No ports: imported by the interface, the picker and the arbiter top.
package ddr3_request_arbiter_pkg;

    localparam int unsigned DDR3_AW = 28;
    localparam int unsigned DDR3_DW = 8;

    typedef enum logic {
        ARB_PRIORITY    = 1'b0,
        ARB_ROUND_ROBIN = 1'b1
    } arb_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ddr3_request_arbiter_if.sv
// Bundle of the per-channel request bus and the shared DDR3 byte-port bus.
// Ports: none. Modports:
//   master - requesters and DDR3 side (drive ch_* strobes/data and ddr3_ready)
//   slave  - the arbiter (drives grants, ready demux, drop flags, muxed DDR3 bus)
interface ddr3_request_arbiter_if
    import ddr3_request_arbiter_pkg::*;
#(
    parameter int unsigned CHANNELS = 4
) ();

    logic [CHANNELS-1:0]         ch_request;
    logic [CHANNELS*DDR3_AW-1:0] ch_addr;
    logic [CHANNELS-1:0]         ch_rd;
    logic [CHANNELS-1:0]         ch_wr;
    logic [CHANNELS*DDR3_DW-1:0] ch_din;
    logic [CHANNELS-1:0]         ch_grant;
    logic [CHANNELS-1:0]         ch_ready;
    logic [CHANNELS-1:0]         ch_drop_err;
    logic [DDR3_AW-1:0]          ddr3_addr;
    logic                        ddr3_rd;
    logic                        ddr3_wr;
    logic [DDR3_DW-1:0]          ddr3_din;
    logic                        ddr3_ready;
    logic                        ddr3_request;

    modport master (
        output ch_request, ch_addr, ch_rd, ch_wr, ch_din, ddr3_ready,
        input  ch_grant, ch_ready, ch_drop_err,
        input  ddr3_addr, ddr3_rd, ddr3_wr, ddr3_din, ddr3_request
    );

    modport slave (
        input  ch_request, ch_addr, ch_rd, ch_wr, ch_din, ddr3_ready,
        output ch_grant, ch_ready, ch_drop_err,
        output ddr3_addr, ddr3_rd, ddr3_wr, ddr3_din, ddr3_request
    );

endinterface

// File: rtl/ddr3_arb_select.sv
// Combinational winner picker: fixed priority (lowest index) or round-robin
// (first requester at or after rr_ptr, wrapping).
// Ports:
//   request    in  CHANNELS  request vector
//   rr_ptr     in  PTR_W     round-robin start index
//   mode       in  arb_mode_t
//   winner     out CHANNELS  one-hot winner, 0 if no request
//   winner_idx out PTR_W     index of the winner
module ddr3_arb_select
    import ddr3_request_arbiter_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PTR_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] request,
    input  logic [PTR_W-1:0]    rr_ptr,
    input  arb_mode_t           mode,
    output logic [CHANNELS-1:0] winner,
    output logic [PTR_W-1:0]    winner_idx
);

    localparam int unsigned SUM_W = PTR_W + 1;

    logic             found;
    logic [SUM_W-1:0] sum;
    logic [PTR_W-1:0] idx;

    // Scan candidates in search order; the first requester wins.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (mode == ARB_ROUND_ROBIN) begin
                sum = {1'b0, rr_ptr} + SUM_W'(k);
            end else begin
                sum = SUM_W'(k);
            end
            if (sum >= SUM_W'(CHANNELS)) begin
                sum = sum - SUM_W'(CHANNELS);
            end
            idx = PTR_W'(sum);
            if (!found && request[idx]) begin
                found       = 1'b1;
                winner[idx] = 1'b1;
                winner_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/ddr3_request_arbiter.sv
// Registered, lockable N-channel arbiter for the single DDR3 byte port.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-high reset (also resets the DDR3 controller)
//   bus   slave modport of ddr3_request_arbiter_if: per-channel request/strobe/
//         data inputs, registered one-hot grant, ready demux, sticky drop flags,
//         and the muxed DDR3 address/strobe/data plus bus-ownership request.
module ddr3_request_arbiter
    import ddr3_request_arbiter_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned MODE     = 0,
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    ddr3_request_arbiter_if.slave bus
);

    localparam int unsigned PTR_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned HOLD_W       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam arb_mode_t   ARB_MODE     = (MODE == 1) ? ARB_ROUND_ROBIN : ARB_PRIORITY;
    localparam bit          HOLD_LIMITED = (MODE == 1) && (MAX_HOLD > 0);

    arb_state_t          state, state_next;
    logic [CHANNELS-1:0] grant, grant_next;
    logic [PTR_W-1:0]    rr_ptr, rr_ptr_next;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                hold_clr;
    logic                pending;
    logic [CHANNELS-1:0] drop_err;

    logic [CHANNELS-1:0] winner;
    logic [PTR_W-1:0]    winner_idx;
    logic [CHANNELS-1:0] strobe;
    logic                holder_req, others_req, hold_full, yield;
    logic                accept, fwd_rd, fwd_wr, done;
    logic [DDR3_AW-1:0]  mux_addr;
    logic [DDR3_DW-1:0]  mux_din;

    ddr3_arb_select #(
        .CHANNELS (CHANNELS),
        .PTR_W    (PTR_W)
    ) u_select (
        .request    (bus.ch_request),
        .rr_ptr     (rr_ptr),
        .mode       (ARB_MODE),
        .winner     (winner),
        .winner_idx (winner_idx)
    );

    assign strobe     = bus.ch_rd | bus.ch_wr;
    assign holder_req = |(bus.ch_request & grant);
    assign others_req = |(bus.ch_request & ~grant);
    assign hold_full  = HOLD_LIMITED && (hold_cnt == HOLD_W'(MAX_HOLD));
    // Exhausted holder stops being offered accesses so the forced release is not raced by a new strobe.
    assign yield      = hold_full & others_req;
    assign accept     = bus.ddr3_ready & ~pending & ~yield;
    assign fwd_rd     = accept & |(bus.ch_rd & grant);
    assign fwd_wr     = accept & |(bus.ch_wr & grant);
    // pending is registered, so this is always at least one cycle after the strobe.
    assign done       = pending & bus.ddr3_ready;

    // One-hot OR mux of the granted channel's address and write data.
    always_comb begin
        mux_addr = '0;
        mux_din  = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                mux_addr = mux_addr | bus.ch_addr[i*DDR3_AW +: DDR3_AW];
                mux_din  = mux_din  | bus.ch_din[i*DDR3_DW +: DDR3_DW];
            end
        end
    end

    assign bus.ch_grant     = grant;
    assign bus.ch_ready     = grant & {CHANNELS{accept}};
    assign bus.ch_drop_err  = drop_err;
    assign bus.ddr3_addr    = mux_addr;
    assign bus.ddr3_din     = mux_din;
    assign bus.ddr3_rd      = fwd_rd;
    assign bus.ddr3_wr      = fwd_wr;
    assign bus.ddr3_request = |grant;

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_next;
            grant  <= grant_next;
            rr_ptr <= rr_ptr_next;
        end
    end

    // Next state: pick on IDLE/RELEASE, hold through GRANT until free and not in flight.
    always_comb begin
        state_next  = state;
        grant_next  = grant;
        rr_ptr_next = rr_ptr;
        hold_clr    = 1'b0;
        case (state)
            ST_IDLE, ST_RELEASE: begin
                if (|bus.ch_request) begin
                    state_next = ST_GRANT;
                    grant_next = winner;
                    hold_clr   = 1'b1;
                    if (ARB_MODE == ARB_ROUND_ROBIN) begin
                        rr_ptr_next = (winner_idx == PTR_W'(CHANNELS - 1)) ? '0
                                                                           : winner_idx + PTR_W'(1);
                    end
                end else begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                end
            end
            ST_GRANT: begin
                if (!pending && !fwd_rd && !fwd_wr && (!holder_req || yield)) begin
                    state_next = ST_RELEASE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    // In-flight flag, holder access counter and sticky drop flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= 1'b0;
            hold_cnt <= '0;
            drop_err <= '0;
        end else begin
            if (fwd_rd || fwd_wr) begin
                pending <= 1'b1;
            end else if (done) begin
                pending <= 1'b0;
            end
            if (hold_clr) begin
                hold_cnt <= '0;
            end else if (done && (hold_cnt != HOLD_W'(MAX_HOLD))) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            drop_err <= drop_err | (strobe & (~grant | {CHANNELS{pending | yield}}));
        end
    end

endmodule

// File: tb/tb_ddr3_request_arbiter.sv
// Bench for ddr3_request_arbiter: a fixed-priority instance driven from a vector
// table and hand sequences, and a round-robin instance (MAX_HOLD=2) streaming reads.
module tb_ddr3_request_arbiter;
    import ddr3_request_arbiter_pkg::*;

    localparam int unsigned N = 4;
    localparam logic [27:0] ADDRS [N] = '{28'h0123456, 28'h0ABCDE1, 28'h0F00D02, 28'h7654321};
    localparam logic [7:0]  DINS  [N] = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    localparam int          NVEC  = 19;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] rd;
        logic [3:0] wr;
        logic       rdy;
        logic [3:0] grant;
        logic [3:0] crdy;
        logic [3:0] drop;
        logic       drd;
        logic       dwr;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ddr3_request_arbiter_if #(.CHANNELS(N)) ifa ();
    ddr3_request_arbiter_if #(.CHANNELS(N)) ifb ();

    ddr3_request_arbiter #(.CHANNELS(N), .MODE(0), .MAX_HOLD(0)) dut_p (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    ddr3_request_arbiter #(.CHANNELS(N), .MODE(1), .MAX_HOLD(2)) dut_r (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] addr_of(input logic [3:0] g);
        logic [27:0] a = '0;
        for (int i = 0; i < N; i++) if (g[i]) a = ADDRS[i];
        return a;
    endfunction

    function automatic logic [7:0] din_of(input logic [3:0] g);
        logic [7:0] d = '0;
        for (int i = 0; i < N; i++) if (g[i]) d = DINS[i];
        return d;
    endfunction

    function automatic logic [63:0] pack_out(input logic [3:0] g, input logic [3:0] crdy,
                                             input logic [3:0] drop, input logic drd, input logic dwr,
                                             input logic [27:0] a, input logic [7:0] d, input logic rq);
        return {13'b0, g, crdy, drop, drd, dwr, a, d, rq};
    endfunction

    function automatic logic [63:0] actual_p();
        return pack_out(ifa.ch_grant, ifa.ch_ready, ifa.ch_drop_err, ifa.ddr3_rd, ifa.ddr3_wr,
                        ifa.ddr3_addr, ifa.ddr3_din, ifa.ddr3_request);
    endfunction

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] rd, input logic [3:0] wr,
                                input logic rdy, input logic [3:0] g, input logic [3:0] crdy,
                                input logic [3:0] drop, input logic drd, input logic dwr);
        vec_t v;
        v.req = req; v.rd = rd; v.wr = wr; v.rdy = rdy;
        v.grant = g; v.crdy = crdy; v.drop = drop; v.drd = drd; v.dwr = dwr;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    vec_t        vecs [NVEC];
    int          ten_ch [$];
    int          ten_rd [$];
    int          gaps [$];
    logic [3:0]  cur;
    int          rd_cnt;
    int          gap_cnt;
    bit          in_ten;
    bit          started;

    initial begin
        reset = 1'b1;
        ifa.ch_request = '0; ifa.ch_rd = '0; ifa.ch_wr = '0; ifa.ddr3_ready = 1'b1;
        ifb.ch_request = '0; ifb.ch_rd = '0; ifb.ch_wr = '0; ifb.ddr3_ready = 1'b1;
        ifa.ch_addr = {ADDRS[3], ADDRS[2], ADDRS[1], ADDRS[0]};
        ifb.ch_addr = {ADDRS[3], ADDRS[2], ADDRS[1], ADDRS[0]};
        ifa.ch_din  = {DINS[3], DINS[2], DINS[1], DINS[0]};
        ifb.ch_din  = {DINS[3], DINS[2], DINS[1], DINS[0]};

        //           req      rd       wr       rdy   grant    crdy     drop     drd   dwr
        vecs[0]  = mk(4'b0100, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        vecs[1]  = mk(4'b0100, 4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0);
        vecs[2]  = mk(4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0);
        vecs[3]  = mk(4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0);
        vecs[4]  = mk(4'b0100, 4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0);
        vecs[5]  = mk(4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0);
        vecs[6]  = mk(4'b1010, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        vecs[7]  = mk(4'b1010, 4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0);
        vecs[8]  = mk(4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0);
        vecs[9]  = mk(4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        vecs[10] = mk(4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0);
        vecs[11] = mk(4'b1000, 4'b0000, 4'b1000, 1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b1);
        vecs[12] = mk(4'b1000, 4'b0000, 4'b0010, 1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        vecs[13] = mk(4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b1000, 4'b1000, 4'b0010, 1'b0, 1'b0);
        vecs[14] = mk(4'b1001, 4'b0000, 4'b1000, 1'b1, 4'b1000, 4'b1000, 4'b0010, 1'b0, 1'b1);
        vecs[15] = mk(4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b1000, 4'b0000, 4'b0010, 1'b0, 1'b0);
        vecs[16] = mk(4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b1000, 4'b1000, 4'b0010, 1'b0, 1'b0);
        vecs[17] = mk(4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0);
        vecs[18] = mk(4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset: everything stays quiet.
        for (int c = 0; c < 20; c++) begin
            smp();
            check($sformatf("idle%0d", c), actual_p(), 64'd0);
        end

        // Fixed-priority vector table.
        for (int i = 0; i < NVEC; i++) begin
            cyc();
            ifa.ch_request = vecs[i].req;
            ifa.ch_rd      = vecs[i].rd;
            ifa.ch_wr      = vecs[i].wr;
            ifa.ddr3_ready = vecs[i].rdy;
            smp();
            check($sformatf("vec%0d", i), actual_p(),
                  pack_out(vecs[i].grant, vecs[i].crdy, vecs[i].drop, vecs[i].drd, vecs[i].dwr,
                           addr_of(vecs[i].grant), din_of(vecs[i].grant), |vecs[i].grant));
        end

        // Holder drops request right after a read while DDR3 stalls for 5 cycles.
        cyc(); ifa.ch_request = 4'b0001; ifa.ch_rd = '0; ifa.ch_wr = '0; ifa.ddr3_ready = 1'b1;
        cyc(); ifa.ch_rd = 4'b0001;
        smp(); check("hold_rd_fwd", {60'd0, ifa.ch_grant}, 64'h1);
        check("hold_rd_strobe", 64'(ifa.ddr3_rd), 64'd1);
        cyc(); ifa.ch_rd = '0; ifa.ch_request = '0; ifa.ddr3_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            smp(); check($sformatf("hold_stall%0d", c), {28'd0, ifa.ddr3_addr, 4'd0, ifa.ch_grant},
                         {28'd0, ADDRS[0], 4'd0, 4'b0001});
            if (c < 4) cyc();
        end
        cyc(); ifa.ddr3_ready = 1'b1;
        smp(); check("hold_ready_back", {56'd0, ifa.ch_ready, ifa.ch_grant}, 64'h01);
        smp(); check("hold_last", {56'd0, ifa.ch_ready, ifa.ch_grant}, 64'h11);
        smp(); check("hold_released", {59'd0, ifa.ddr3_request, ifa.ch_grant}, 64'h0);
        check("drop_sticky", 64'(ifa.ch_drop_err), 64'h2);

        // Round-robin streaming: ch0 and ch2 read whenever offered.
        cyc(); ifb.ch_request = 4'b0101;
        in_ten = 1'b0; started = 1'b0; rd_cnt = 0; gap_cnt = 0; cur = '0;
        for (int c = 0; c < 300 && ten_ch.size() < 4; c++) begin
            cyc();
            ifb.ch_rd = ifb.ch_ready;
            smp();
            if (ifb.ch_grant != 4'b0000) begin
                if (in_ten && ifb.ch_grant != cur) begin
                    ten_ch.push_back(int'(cur)); ten_rd.push_back(rd_cnt);
                    gaps.push_back(0);
                    cur = ifb.ch_grant; rd_cnt = 0;
                end else if (!in_ten) begin
                    if (started) gaps.push_back(gap_cnt);
                    in_ten = 1'b1; cur = ifb.ch_grant; rd_cnt = 0;
                end
                if (ifb.ddr3_rd) rd_cnt++;
            end else begin
                if (in_ten) begin
                    ten_ch.push_back(int'(cur)); ten_rd.push_back(rd_cnt);
                    in_ten = 1'b0; started = 1'b1; gap_cnt = 0;
                end
                gap_cnt++;
            end
        end
        cyc(); ifb.ch_rd = '0; ifb.ch_request = '0;
        if (ten_ch.size() < 4) begin
            check("rr_timeout", 64'(ten_ch.size()), 64'd4);
        end else begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("rr_chan%0d", k), 64'(ten_ch[k]), (k % 2 == 0) ? 64'h1 : 64'h4);
                check($sformatf("rr_reads%0d", k), 64'(ten_rd[k]), 64'd2);
                if (k < 3) check($sformatf("rr_gap%0d", k), 64'(gaps[k]), 64'd1);
            end
        end
        check("rr_no_drop", 64'(ifb.ch_drop_err), 64'd0);
        repeat (3) cyc();

        // Reset while an access is in flight.
        ifa.ch_request = 4'b0001; ifa.ddr3_ready = 1'b1;
        cyc(); ifa.ch_rd = 4'b0001;
        smp(); check("rst_pre_rd", {35'd0, ifa.ddr3_rd, ifa.ddr3_addr}, {35'd0, 1'b1, 28'h0123456});
        cyc(); ifa.ch_rd = '0; ifa.ddr3_ready = 1'b0;
        smp(); check("rst_pre_pending", {4'd0, ifa.ch_ready, 28'd0, ifa.ddr3_addr},
                     {4'd0, 4'b0000, 28'd0, 28'h0123456});
        #2 reset = 1'b1;
        #1 check("rst_same_cycle", {31'd0, ifa.ddr3_request, ifa.ch_grant, ifa.ddr3_addr}, 64'd0);
        ifa.ch_request = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; ifa.ddr3_ready = 1'b1;
        smp();
        check("rst_state_idle", 64'(dut_p.state), 64'(ST_IDLE));
        check("rst_rr_ptr_p", 64'(dut_p.rr_ptr), 64'd0);
        check("rst_rr_ptr_r", 64'(dut_r.rr_ptr), 64'd0);
        check("rst_pending", 64'(dut_p.pending), 64'd0);
        check("rst_outputs", actual_p(), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
